// File: rtl/lcd_16207_responder_if.sv
// ---------------------------------------------------------------------------
// lcd_16207_responder_if
// Control strobes of an HD44780-style (16207) character LCD bus.
//   LCD_E  : enable strobe, a transaction completes on its falling edge
//   LCD_RS : register select, 0 = instruction/status, 1 = data
//   LCD_RW : direction, 0 = write, 1 = read
// The 8-bit data bus is bidirectional and travels as a plain inout port of
// the responder so that its tri-state drivers stay at module boundaries.
// master : the initiator (controller or bench) driving the strobes
// slave  : the responder observing them
// ---------------------------------------------------------------------------
interface lcd_16207_responder_if;
   logic LCD_E;
   logic LCD_RS;
   logic LCD_RW;

   modport master (output LCD_E, output LCD_RS, output LCD_RW);
   modport slave  (input  LCD_E, input  LCD_RS, input  LCD_RW);
endinterface

// File: rtl/lcd_16207_responder.sv
// ---------------------------------------------------------------------------
// lcd_16207_responder
// Behavioural stand-in for a 16x2 character LCD controller. It accepts
// instruction/data writes and status/data reads on the LCD bus, keeps an
// 80-character DDRAM and exposes it for display readout.
//   clk        : single clock, all state changes on the rising edge
//   reset      : synchronous active-high reset, starts a DDRAM clear fill
//   lcd        : E/RS/RW strobes (slave modport)
//   LCD_data   : bidirectional data bus, driven only while E=1 and RW=1
//   disp_addr  : linear character index 0..79 for readout
//   disp_char  : DDRAM content at disp_addr, one cycle latency
//   display_on : display-control D bit
//   busy       : busy flag
//   violation  : one-cycle pulse when a write completes while busy
// ---------------------------------------------------------------------------
module lcd_16207_responder #(
   parameter int BUSY_CYCLES = 40,
   parameter int BUSY_HOME   = 160
) (
   input  logic                 clk,
   input  logic                 reset,
   lcd_16207_responder_if.slave lcd,
   inout  wire  [7:0]           LCD_data,
   input  logic [6:0]           disp_addr,
   output logic [7:0]           disp_char,
   output logic                 display_on,
   output logic                 busy,
   output logic                 violation
);
   localparam int CNT_MAX = (BUSY_HOME > BUSY_CYCLES) ? BUSY_HOME : BUSY_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, BUSY, CLEAR} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [6:0]    clr_q, clr_d;
   logic [6:0]    ac_q, ac_d;
   logic          id_q, id_d;
   logic          display_on_q, display_on_d;
   logic          violation_q, violation_d;
   logic [7:0]    disp_char_q, disp_char_d;
   logic          e_q, e_d;
   logic          rs_q, rs_d;
   logic          rw_q, rw_d;
   logic [7:0]    data_q, data_d;
   logic [7:0]    rd_q, rd_d;
   logic [7:0]    ddram_q [80];

   logic          mem_we;
   logic [6:0]    mem_idx;
   logic [7:0]    mem_wdata;
   logic [6:0]    ac_idx;
   logic          complete;
   logic          go_busy;
   logic          go_home;
   logic [7:0]    bus_out;

   // Address counter stepping: the two 40-character lines form one ring
   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
      if (inc) begin
         if (a == 7'h27) return 7'h40;
         if (a == 7'h67) return 7'h00;
         return a + 7'd1;
      end
      if (a == 7'h00) return 7'h67;
      if (a == 7'h40) return 7'h27;
      return a - 7'd1;
   endfunction

   assign busy       = (state_q != IDLE);
   assign display_on = display_on_q;
   assign violation  = violation_q;
   assign disp_char  = disp_char_q;

   // Line 2 starts at AC 0x40 but at linear index 40
   assign ac_idx = ac_q[6] ? (7'd40 + {1'b0, ac_q[5:0]}) : {1'b0, ac_q[5:0]};

   // Read data: status is live; DDRAM data comes from the snapshot taken on the
   // first E-high cycle, bypassed during that first cycle itself
   always_comb begin
      bus_out = {busy, ac_q};
      if (lcd.LCD_RS) begin
         if (busy)     bus_out = 8'hFF;
         else if (e_q) bus_out = rd_q;
         else          bus_out = ddram_q[ac_idx];
      end
   end

   assign LCD_data = (lcd.LCD_E && lcd.LCD_RW) ? bus_out : 8'hzz;

   // Bus capture: strobes and data are held from the last E-high cycle
   always_comb begin
      e_d    = lcd.LCD_E;
      rs_d   = lcd.LCD_E ? lcd.LCD_RS : rs_q;
      rw_d   = lcd.LCD_E ? lcd.LCD_RW : rw_q;
      data_d = lcd.LCD_E ? LCD_data   : data_q;
      rd_d   = (lcd.LCD_E && !e_q) ? ddram_q[ac_idx] : rd_q;
      disp_char_d = (disp_addr < 7'd80) ? ddram_q[disp_addr] : 8'h20;
   end

   // Main controller: busy timer, clear fill and command execution at the
   // falling edge of E
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      clr_d        = clr_q;
      ac_d         = ac_q;
      id_d         = id_q;
      display_on_d = display_on_q;
      violation_d  = 1'b0;
      mem_we       = 1'b0;
      mem_idx      = clr_q;
      mem_wdata    = 8'h20;
      go_busy      = 1'b0;
      go_home      = 1'b0;
      complete     = e_q && !lcd.LCD_E;

      case (state_q)
         BUSY: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         CLEAR: begin
            mem_we = 1'b1;
            if (clr_q == 7'd79) begin
               state_d = IDLE;
               ac_d    = 7'h00;
               id_d    = 1'b1;
            end else begin
               clr_d = clr_q + 7'd1;
            end
         end
         default: ;
      endcase

      if (complete) begin
         if (!rw_q) begin
            if (busy) begin
               // A NOP instruction write is harmless even while busy
               violation_d = rs_q || (data_q != 8'h00);
            end else if (rs_q) begin
               mem_we    = 1'b1;
               mem_idx   = ac_idx;
               mem_wdata = data_q;
               ac_d      = ac_step(ac_q, id_q);
               go_busy   = 1'b1;
            end else begin
               casez (data_q)
                  8'b1???????: begin
                     // Out-of-range addresses snap to the start of their line
                     ac_d    = {data_q[6], (data_q[5:0] > 6'd39) ? 6'd0 : data_q[5:0]};
                     go_busy = 1'b1;
                  end
                  8'b01??????, 8'b001?????, 8'b0001????: go_busy = 1'b1;
                  8'b00001???: begin
                     display_on_d = data_q[2];
                     go_busy      = 1'b1;
                  end
                  8'b000001??: begin
                     id_d    = data_q[1];
                     go_busy = 1'b1;
                  end
                  8'b0000001?: begin
                     ac_d    = 7'h00;
                     go_home = 1'b1;
                  end
                  8'b00000001: begin
                     state_d = CLEAR;
                     clr_d   = 7'd0;
                  end
                  default: ;
               endcase
            end
         end else if (rs_q && !busy) begin
            ac_d = ac_step(ac_q, id_q);
         end
      end

      if (go_busy) begin
         state_d = BUSY;
         cnt_d   = CW'(BUSY_CYCLES - 1);
      end
      if (go_home) begin
         state_d = BUSY;
         cnt_d   = CW'(BUSY_HOME - 1);
      end

      if (reset) mem_we = 1'b0;
   end

   // Controller state; reset restarts the clear fill from index 0
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= CLEAR;
         cnt_q        <= '0;
         clr_q        <= 7'd0;
         ac_q         <= 7'h00;
         id_q         <= 1'b1;
         display_on_q <= 1'b0;
         violation_q  <= 1'b0;
         disp_char_q  <= 8'h20;
         e_q          <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         clr_q        <= clr_d;
         ac_q         <= ac_d;
         id_q         <= id_d;
         display_on_q <= display_on_d;
         violation_q  <= violation_d;
         disp_char_q  <= disp_char_d;
         e_q          <= e_d;
      end
   end

   // Captured bus values need no reset: e_q gates their use
   always_ff @(posedge clk) begin
      rs_q   <= rs_d;
      rw_q   <= rw_d;
      data_q <= data_d;
      rd_q   <= rd_d;
   end

   // DDRAM storage, single write port
   always_ff @(posedge clk) begin
      if (mem_we) ddram_q[mem_idx] <= mem_wdata;
   end
endmodule

// File: tb/tb_lcd_16207_responder.sv
// ---------------------------------------------------------------------------
// tb_lcd_16207_responder
// Self-checking bench for lcd_16207_responder. A behavioural model keeps the
// DDRAM as an array, the address as a linear ring position and the busy flag
// as the cycle number at which it drops.
// ---------------------------------------------------------------------------
module tb_lcd_16207_responder;
   localparam int BUSY_CYCLES = 40;
   localparam int BUSY_HOME   = 160;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] disp_addr = 7'd0;
   logic [7:0] disp_char;
   logic       display_on;
   logic       busy;
   logic       violation;
   logic       drv_en = 1'b0;
   logic [7:0] drv_val = 8'h00;
   wire  [7:0] lcd_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] m_mem [80];
   logic [6:0] m_ac;
   logic       m_id;
   logic       m_disp_on;
   int         m_busy_end;
   logic       m_exp_viol;

   lcd_16207_responder_if lcd_bus();

   assign lcd_data = drv_en ? drv_val : 8'hzz;

   lcd_16207_responder #(
      .BUSY_CYCLES(BUSY_CYCLES),
      .BUSY_HOME  (BUSY_HOME)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .lcd       (lcd_bus),
      .LCD_data  (lcd_data),
      .disp_addr (disp_addr),
      .disp_char (disp_char),
      .display_on(display_on),
      .busy      (busy),
      .violation (violation)
   );

   // Free-running clock and cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Absolute time limit so the run always ends
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Model helpers: AC <-> ring position 0..79
   function automatic int lin_of(input logic [6:0] a);
      return (a[6] ? 40 : 0) + int'(a[5:0]);
   endfunction

   function automatic logic [6:0] ac_of(input int l);
      return (l < 40) ? 7'(l) : 7'(l - 40 + 64);
   endfunction

   function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
      int l;
      l = lin_of(a);
      l = inc ? (l + 1) % 80 : (l + 79) % 80;
      return ac_of(l);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
      m_ac       = 7'h00;
      m_id       = 1'b1;
      m_disp_on  = 1'b0;
      m_busy_end = cyc + 80;
   endtask

   // Model effect of a write completing at the next rising edge
   task automatic m_apply_write(input logic rs, input logic [7:0] d);
      int c;
      int low;
      c = cyc + 1;
      m_exp_viol = 1'b0;
      if (cyc < m_busy_end) begin
         m_exp_viol = rs || (d != 8'h00);
      end else if (rs) begin
         m_mem[lin_of(m_ac)] = d;
         m_ac       = m_step(m_ac, m_id);
         m_busy_end = c + BUSY_CYCLES;
      end else if (d >= 8'h80) begin
         low = int'(d) % 64;
         if (low >= 40) m_ac = d[6] ? 7'h40 : 7'h00;
         else           m_ac = d[6:0];
         m_busy_end = c + BUSY_CYCLES;
      end else if (d >= 8'h10) begin
         m_busy_end = c + BUSY_CYCLES;
      end else if (d >= 8'h08) begin
         m_disp_on  = d[2];
         m_busy_end = c + BUSY_CYCLES;
      end else if (d >= 8'h04) begin
         m_id       = d[1];
         m_busy_end = c + BUSY_CYCLES;
      end else if (d >= 8'h02) begin
         m_ac       = 7'h00;
         m_busy_end = c + BUSY_HOME;
      end else if (d == 8'h01) begin
         for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
         m_ac       = 7'h00;
         m_id       = 1'b1;
         m_busy_end = c + 80;
      end
   endtask

   // Bus write; returns at the first negedge after completion with violation
   task automatic lcd_write(input logic rs, input logic [7:0] d, output logic viol);
      @(negedge clk);
      lcd_bus.LCD_E  = 1'b1;
      lcd_bus.LCD_RS = rs;
      lcd_bus.LCD_RW = 1'b0;
      drv_en  = 1'b1;
      drv_val = d;
      @(negedge clk);
      @(negedge clk);
      lcd_bus.LCD_E = 1'b0;
      drv_en = 1'b0;
      m_apply_write(rs, d);
      @(negedge clk);
      viol = violation;
   endtask

   // Bus read; samples in the second E-high cycle
   task automatic lcd_read(input logic rs, output logic [7:0] val);
      @(negedge clk);
      lcd_bus.LCD_E  = 1'b1;
      lcd_bus.LCD_RS = rs;
      lcd_bus.LCD_RW = 1'b1;
      drv_en = 1'b0;
      @(negedge clk);
      val = lcd_data;
      lcd_bus.LCD_E = 1'b0;
      if (rs && !(cyc < m_busy_end)) m_ac = m_step(m_ac, m_id);
      @(negedge clk);
      lcd_bus.LCD_RW = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (cyc < m_busy_end && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
   endtask

   // Reset for n cycles; optionally with a data write pending on the bus whose
   // E falls together with reset
   task automatic do_reset(input int n, input logic hold_write);
      @(negedge clk);
      reset = 1'b1;
      lcd_bus.LCD_E  = hold_write;
      lcd_bus.LCD_RS = 1'b1;
      lcd_bus.LCD_RW = 1'b0;
      drv_en  = hold_write;
      drv_val = 8'h55;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      lcd_bus.LCD_E = 1'b0;
      drv_en = 1'b0;
      m_reset();
   endtask

   task automatic test_reset();
      int cnt;
      logic [7:0] s;
      do_reset(3, 1'b1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy got %b expected 1", busy); end
      checks++;
      if (disp_char !== 8'h20) begin errors++; $display("[TB] FAIL reset_disp_char got %h expected 20", disp_char); end
      checks++;
      if (display_on !== 1'b0) begin errors++; $display("[TB] FAIL reset_display_on got %b expected 0", display_on); end
      checks++;
      if (violation !== 1'b0) begin errors++; $display("[TB] FAIL reset_violation got %b expected 0", violation); end
      cnt = 0;
      while (busy === 1'b1 && cnt < 300) begin
         cnt++;
         if (cnt == 2) begin
            checks++;
            if (violation !== 1'b0) begin errors++; $display("[TB] FAIL reset_edge_completion got violation %b expected 0", violation); end
         end
         @(negedge clk);
      end
      checks++;
      if (cnt != 80) begin errors++; $display("[TB] FAIL reset_busy_cycles got %0d expected 80", cnt); end
      lcd_read(1'b0, s);
      checks++;
      if (s !== 8'h00) begin errors++; $display("[TB] FAIL reset_status got %h expected 00", s); end
      for (int i = 0; i < 80; i++) begin
         disp_addr = 7'(i);
         @(negedge clk);
         checks++;
         if (disp_char !== 8'h20) begin errors++; $display("[TB] FAIL reset_fill idx %0d got %h expected 20", i, disp_char); end
      end
   endtask

   task automatic test_wrap();
      logic v;
      logic [7:0] s;
      wait_idle();
      lcd_write(1'b0, 8'hA7, v);
      wait_idle();
      lcd_write(1'b1, 8'h41, v);
      checks++;
      if (v !== 1'b0) begin errors++; $display("[TB] FAIL wrap_violation got %b expected 0", v); end
      wait_idle();
      lcd_read(1'b0, s);
      checks++;
      if (s !== 8'h40) begin errors++; $display("[TB] FAIL wrap_status got %h expected 40", s); end
      disp_addr = 7'd39;
      @(negedge clk);
      checks++;
      if (disp_char !== 8'h41) begin errors++; $display("[TB] FAIL wrap_disp got %h expected 41", disp_char); end
   endtask

   task automatic test_decrement();
      logic v;
      logic [7:0] s;
      wait_idle(); lcd_write(1'b0, 8'h04, v);
      wait_idle(); lcd_write(1'b0, 8'hC0, v);
      wait_idle(); lcd_write(1'b1, 8'h42, v);
      wait_idle(); lcd_read(1'b0, s);
      checks++;
      if (s !== 8'h27) begin errors++; $display("[TB] FAIL dec_status_1 got %h expected 27", s); end
      wait_idle(); lcd_write(1'b0, 8'h80, v);
      wait_idle(); lcd_write(1'b1, 8'h43, v);
      wait_idle(); lcd_read(1'b0, s);
      checks++;
      if (s !== 8'h67) begin errors++; $display("[TB] FAIL dec_status_2 got %h expected 67", s); end
      disp_addr = 7'd40;
      @(negedge clk);
      checks++;
      if (disp_char !== 8'h42) begin errors++; $display("[TB] FAIL dec_disp40 got %h expected 42", disp_char); end
      disp_addr = 7'd0;
      @(negedge clk);
      checks++;
      if (disp_char !== 8'h43) begin errors++; $display("[TB] FAIL dec_disp0 got %h expected 43", disp_char); end
      wait_idle(); lcd_write(1'b0, 8'h06, v);
   endtask

   task automatic test_violation();
      logic v;
      logic [7:0] s;
      wait_idle(); lcd_write(1'b0, 8'h85, v);
      wait_idle(); lcd_write(1'b1, 8'h61, v);
      repeat (4) @(negedge clk);
      lcd_write(1'b1, 8'h62, v);
      checks++;
      if (v !== 1'b1) begin errors++; $display("[TB] FAIL viol_pulse got %b expected 1", v); end
      @(negedge clk);
      checks++;
      if (violation !== 1'b0) begin errors++; $display("[TB] FAIL viol_one_cycle got %b expected 0", violation); end
      wait_idle();
      lcd_read(1'b0, s);
      checks++;
      if (s !== 8'h06) begin errors++; $display("[TB] FAIL viol_ac got %h expected 06", s); end
      disp_addr = 7'd5;
      @(negedge clk);
      checks++;
      if (disp_char !== 8'h61) begin errors++; $display("[TB] FAIL viol_disp5 got %h expected 61", disp_char); end
      disp_addr = 7'd6;
      @(negedge clk);
      checks++;
      if (disp_char !== 8'h20) begin errors++; $display("[TB] FAIL viol_disp6 got %h expected 20", disp_char); end
   endtask

   task automatic test_same_index();
      logic v;
      logic [7:0] old;
      wait_idle(); lcd_write(1'b0, 8'h8A, v);
      wait_idle();
      disp_addr = 7'd10;
      old = m_mem[10];
      lcd_write(1'b1, 8'h5A, v);
      checks++;
      if (disp_char !== old) begin errors++; $display("[TB] FAIL same_index_old got %h expected %h", disp_char, old); end
      @(negedge clk);
      checks++;
      if (disp_char !== 8'h5A) begin errors++; $display("[TB] FAIL same_index_new got %h expected 5a", disp_char); end
   endtask

   task automatic test_read_while_busy();
      logic v;
      logic [7:0] r;
      logic [7:0] exp;
      wait_idle(); lcd_write(1'b0, 8'h8B, v);
      wait_idle(); lcd_write(1'b1, 8'h77, v);
      lcd_read(1'b1, r);
      checks++;
      if (r !== 8'hFF) begin errors++; $display("[TB] FAIL busy_data_read got %h expected ff", r); end
      exp = {1'b1, m_ac};
      lcd_read(1'b0, r);
      checks++;
      if (r !== exp) begin errors++; $display("[TB] FAIL busy_status got %h expected %h", r, exp); end
      wait_idle(); lcd_write(1'b0, 8'h8B, v);
      wait_idle(); lcd_read(1'b1, r);
      checks++;
      if (r !== 8'h77) begin errors++; $display("[TB] FAIL data_read got %h expected 77", r); end
      lcd_read(1'b0, r);
      checks++;
      if (r !== 8'h0C) begin errors++; $display("[TB] FAIL data_read_ac got %h expected 0c", r); end
   endtask

   task automatic test_clamp_and_clear();
      logic v;
      logic [7:0] s;
      int cnt;
      wait_idle(); lcd_write(1'b0, 8'hB0, v);
      wait_idle(); lcd_read(1'b0, s);
      checks++;
      if (s !== 8'h00) begin errors++; $display("[TB] FAIL clamp_line1 got %h expected 00", s); end
      wait_idle(); lcd_write(1'b0, 8'hF5, v);
      wait_idle(); lcd_read(1'b0, s);
      checks++;
      if (s !== 8'h40) begin errors++; $display("[TB] FAIL clamp_line2 got %h expected 40", s); end
      wait_idle(); lcd_write(1'b0, 8'h0C, v);
      checks++;
      if (display_on !== 1'b1) begin errors++; $display("[TB] FAIL display_on got %b expected 1", display_on); end
      wait_idle(); lcd_write(1'b0, 8'h01, v);
      cnt = 0;
      while (busy === 1'b1 && cnt < 300) begin
         cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt != 80) begin errors++; $display("[TB] FAIL clear_busy_cycles got %0d expected 80", cnt); end
      wait_idle(); lcd_read(1'b0, s);
      checks++;
      if (s !== 8'h00) begin errors++; $display("[TB] FAIL clear_ac got %h expected 00", s); end
      disp_addr = 7'd40;
      @(negedge clk);
      checks++;
      if (disp_char !== 8'h20) begin errors++; $display("[TB] FAIL clear_disp40 got %h expected 20", disp_char); end
   endtask

   task automatic test_disp_range();
      int a;
      for (int i = 0; i < 6; i++) begin
         a = 80 + int'($urandom_range(0, 47));
         disp_addr = 7'(a);
         @(negedge clk);
         checks++;
         if (disp_char !== 8'h20) begin errors++; $display("[TB] FAIL disp_range addr %0d got %h expected 20", a, disp_char); end
      end
   endtask

   task automatic test_random();
      logic v;
      logic [7:0] r;
      logic [7:0] d;
      logic [7:0] exp;
      int op;
      int a;
      for (int n = 0; n < 80; n++) begin
         op = int'($urandom_range(0, 8));
         d  = 8'($urandom);
         case (op)
            0, 7: begin
               if (op == 0) wait_idle();
               lcd_write(1'b1, d, v);
               checks++;
               if (v !== m_exp_viol) begin errors++; $display("[TB] FAIL rnd_data_write_viol got %b expected %b", v, m_exp_viol); end
            end
            1: begin
               wait_idle(); lcd_write(1'b0, 8'h80 | d, v);
               checks++;
               if (v !== m_exp_viol) begin errors++; $display("[TB] FAIL rnd_setaddr_viol got %b expected %b", v, m_exp_viol); end
            end
            2: begin
               wait_idle(); lcd_write(1'b0, {6'b000001, d[1:0]}, v);
            end
            3: begin
               wait_idle(); lcd_write(1'b0, {5'b00001, d[2:0]}, v);
               checks++;
               if (display_on !== m_disp_on) begin errors++; $display("[TB] FAIL rnd_display_on got %b expected %b", display_on, m_disp_on); end
            end
            4: begin
               wait_idle();
               exp = {1'b0, m_ac};
               lcd_read(1'b0, r);
               checks++;
               if (r !== exp) begin errors++; $display("[TB] FAIL rnd_status got %h expected %h", r, exp); end
            end
            5: begin
               wait_idle();
               exp = m_mem[lin_of(m_ac)];
               lcd_read(1'b1, r);
               checks++;
               if (r !== exp) begin errors++; $display("[TB] FAIL rnd_data_read got %h expected %h", r, exp); end
            end
            6: begin
               a = int'($urandom_range(0, 127));
               disp_addr = 7'(a);
               @(negedge clk);
               exp = (a < 80) ? m_mem[a] : 8'h20;
               checks++;
               if (disp_char !== exp) begin errors++; $display("[TB] FAIL rnd_disp addr %0d got %h expected %h", a, disp_char, exp); end
            end
            default: begin
               wait_idle(); lcd_write(1'b0, 8'(16 + int'(d) % 112), v);
            end
         endcase
      end
      wait_idle();
      exp = {1'b0, m_ac};
      lcd_read(1'b0, r);
      checks++;
      if (r !== exp) begin errors++; $display("[TB] FAIL rnd_final_status got %h expected %h", r, exp); end
   endtask

   task automatic test_reset_during_home();
      logic v;
      logic [7:0] s;
      int cnt;
      wait_idle(); lcd_write(1'b0, 8'h80, v);
      wait_idle(); lcd_write(1'b1, 8'h99, v);
      wait_idle(); lcd_write(1'b0, 8'h02, v);
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL home_busy got %b expected 1", busy); end
      do_reset(2, 1'b0);
      cnt = 0;
      while (busy === 1'b1 && cnt < 300) begin
         cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt != 80) begin errors++; $display("[TB] FAIL home_reset_busy_cycles got %0d expected 80", cnt); end
      checks++;
      if (display_on !== 1'b0) begin errors++; $display("[TB] FAIL home_reset_display_on got %b expected 0", display_on); end
      lcd_read(1'b0, s);
      checks++;
      if (s !== 8'h00) begin errors++; $display("[TB] FAIL home_reset_status got %h expected 00", s); end
      for (int i = 0; i < 80; i++) begin
         disp_addr = 7'(i);
         @(negedge clk);
         checks++;
         if (disp_char !== 8'h20) begin errors++; $display("[TB] FAIL home_reset_fill idx %0d got %h expected 20", i, disp_char); end
      end
   endtask

   initial begin
      lcd_bus.LCD_E  = 1'b0;
      lcd_bus.LCD_RS = 1'b0;
      lcd_bus.LCD_RW = 1'b0;
      m_reset();
      $display("[TB] starting lcd_16207_responder bench");
      test_reset();
      test_wrap();
      test_decrement();
      test_violation();
      test_same_index();
      test_read_while_busy();
      test_clamp_and_clear();
      test_disp_range();
      test_random();
      test_reset_during_home();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
